// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write-to-read bypass and a per-register busy scoreboard.
// Optional macro REGFILE_RD_REG_EN registers rdata_o/rbusy_o for a 1-cycle read latency.
module regfile_mp_rdport #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NUM_WR = 1
) (
  input  logic [AW-1:0]          raddr,
  input  logic [NUM_WR-1:0]      we,
  input  logic [NUM_WR*AW-1:0]   waddr,
  input  logic [NUM_WR*XLEN-1:0] wdata,
  input  logic [XLEN-1:0]        arr_data,
  input  logic                   arr_busy,
  output logic [XLEN-1:0]        rdata,
  output logic                   rbusy
);
  logic hit;

  // Ascending scan: the highest-index matching write port overrides earlier ones.
  always_comb begin
    hit   = 1'b0;
    rdata = arr_data;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k] && (waddr[k*AW +: AW] == raddr) && (raddr != '0)) begin
        hit   = 1'b1;
        rdata = wdata[k*XLEN +: XLEN];
      end
    end
    rbusy = arr_busy & ~hit;
  end
endmodule

module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_WR-1:0]      we_i,
  input  logic [NUM_WR*AW-1:0]   waddr_i,
  input  logic [NUM_WR*XLEN-1:0] wdata_i,
  input  logic [NUM_RD*AW-1:0]   raddr_i,
  output logic [NUM_RD*XLEN-1:0] rdata_o,
  output logic [NUM_RD-1:0]      rbusy_o,
  input  logic                   iss_valid_i,
  input  logic [AW-1:0]          iss_rd_i,
  output logic [NUM_REGS-1:0]    busy_vec_o
);
  logic [NUM_REGS-1:0][XLEN-1:0] regs;
  logic [NUM_REGS-1:0][XLEN-1:0] wr_data;
  logic [NUM_REGS-1:0]           wr_en;
  logic [NUM_REGS-1:0]           busy;
  logic [NUM_REGS-1:0]           iss_set;

  // Per-register write decode; x0 is never enabled so it stays at its reset value.
  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    iss_set = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we_i[k] && (waddr_i[k*AW +: AW] == AW'(r))) begin
          wr_en[r]   = 1'b1;
          wr_data[r] = wdata_i[k*XLEN +: XLEN];
        end
      end
      iss_set[r] = iss_valid_i && (iss_rd_i == AW'(r));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      busy <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        if (wr_en[r]) regs[r] <= wr_data[r];
      // A fresh issue outranks the clear from an older producer's writeback.
      busy <= (busy & ~wr_en) | iss_set;
    end
  end

  assign busy_vec_o = busy;

  logic [NUM_RD-1:0][XLEN-1:0] rd_data_c;
  logic [NUM_RD-1:0]           rd_busy_c;

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    regfile_mp_rdport #(.XLEN(XLEN), .AW(AW), .NUM_WR(NUM_WR)) u_rd (
      .raddr   (raddr_i[j*AW +: AW]),
      .we      (we_i),
      .waddr   (waddr_i),
      .wdata   (wdata_i),
      .arr_data(regs[raddr_i[j*AW +: AW]]),
      .arr_busy(busy[raddr_i[j*AW +: AW]]),
      .rdata   (rd_data_c[j]),
      .rbusy   (rd_busy_c[j])
    );
  end

`ifdef REGFILE_RD_REG_EN
  logic [NUM_RD-1:0][XLEN-1:0] rd_data_q;
  logic [NUM_RD-1:0]           rd_busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_c;
      rd_busy_q <= rd_busy_c;
    end
  end

  assign rdata_o = rd_data_q;
  assign rbusy_o = rd_busy_q;
`else
  assign rdata_o = rd_data_c;
  assign rbusy_o = rd_busy_c;
`endif
endmodule
